// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver and its transmitter
// sibling: FSM state encoding, legal configuration ranges and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 8;
  localparam int OVERSAMPLE_MAX = 32;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  // XOR reduction over a zero-extended data word; zero padding does not
  // change the result, so any legal width can be passed in.
  function automatic logic uart_parity(input logic [DATA_BITS_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-stream handshake between the UART receiver (master) and its consumer
// (slave): word, valid/ready and per-word error flags plus the overrun pulse.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divisor counter that can be held
// at zero so the next count phase is set by an external event (start edge).
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  // Divisor counter: wraps at CLK_DIV-1, forced to 0 while clear is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (clear || div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with 2-flop input synchroniser,
// mid-bit sampling, false-start rejection, frame-error/overrun detection and
// a valid/ready output holding register.
// Optional parity: define UART_RX_PARITY_EN to expect a parity bit after the
// data bits; otherwise parity_err is tied to 0.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  output logic             busy,
  uart_rx_os_if.master     rx
);

  generate
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX ||
        (OVERSAMPLE % 2) != 0 || CLK_DIV < 2 ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx_os: illegal parameter combination");
    end
  endgenerate

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] MID_CNT   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] BIT_CNT   = OSW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_t            state, state_n;
  logic [1:0]           sync;
  logic                 rxd_s;
  logic                 tick;
  logic                 baud_clear;
  logic                 sample;
  logic                 done;
  logic                 load;
  logic [OSW-1:0]       os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 ferr_acc;
  logic                 perr_acc;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rxd};
    end
  end

  assign rxd_s      = sync[1];
  assign baud_clear = (state == IDLE);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode; sample marks a mid-bit sampling instant, done marks
  // the final stop-bit sample (frame completion).
  always_comb begin
    state_n = state;
    sample  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) state_n = START;
      end
      START: begin
        if (tick && os_cnt == MID_CNT) begin
          sample  = 1'b1;
          state_n = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && os_cnt == BIT_CNT) begin
          sample = 1'b1;
          if (bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && os_cnt == BIT_CNT) begin
          sample  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && os_cnt == BIT_CNT) begin
          sample = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Tick-within-bit and bit-within-state counters; both restart at every
  // sampling instant that changes state so each field counts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else if (sample) begin
      os_cnt  <= '0;
      bit_cnt <= (state_n == state) ? bit_cnt + 4'd1 : 4'd0;
    end else if (tick) begin
      os_cnt  <= os_cnt + 1'b1;
    end
  end

  // Data shift register, LSB arrives first so new bits enter at the top.
  always_ff @(posedge clk) begin
    if (sample && state == DATA) begin
      shift <= {rxd_s, shift[DATA_BITS-1:1]};
    end
  end

  // Stop-bit error accumulator, cleared between frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ferr_acc <= 1'b0;
    end else if (state == IDLE) begin
      ferr_acc <= 1'b0;
    end else if (sample && state == STOP && !rxd_s) begin
      ferr_acc <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check captured at the parity-bit sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_acc <= 1'b0;
    end else if (sample && state == PARITY) begin
      perr_acc <= (uart_parity(DATA_BITS_MAX'(shift)) ^ rxd_s) != (PARITY_ODD != 0);
    end
  end
`else
  assign perr_acc = 1'b0;
`endif

  // A handshake in the completion cycle frees the holding register.
  assign load = done && (!rx.rx_valid || rx.rx_ready);

  // Output holding register with overrun detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.overrun <= done && rx.rx_valid && !rx.rx_ready;
      if (load) begin
        rx.rx_data    <= shift;
        rx.frame_err  <= ferr_acc | ~rxd_s;
        rx.parity_err <= perr_acc;
        rx.rx_valid   <= 1'b1;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid   <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are built from bit-level rules, the
// expected word is queued when a frame is sent, and an independent monitor
// compares every accepted word.
module tb_uart_rx_os;
  localparam int DATA_BITS  = 8;
  localparam int CLK_DIV    = 4;
  localparam int OVERSAMPLE = 16;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
  localparam int BIT_CLK    = CLK_DIV * OVERSAMPLE;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rxd   = 1'b1;
  logic busy;

  uart_rx_os_if #(.DATA_BITS(DATA_BITS)) rx ();

  uart_rx_os #(
    .DATA_BITS  (DATA_BITS),
    .CLK_DIV    (CLK_DIV),
    .OVERSAMPLE (OVERSAMPLE),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .busy  (busy),
    .rx    (rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic                 fe;
    logic                 pe;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ov_seen = 0;
  int   ov_exp = 0;
  int   ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
  logic prev_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // rx_ready driver, updated just after each rising edge.
  initial begin
    rx.rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rx.rx_ready = 1'b0;
        1:       rx.rx_ready = 1'b1;
        default: rx.rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every accepted word against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_acc = 1'b0;
      end else begin
        if (rx.overrun) ov_seen++;
        if (prev_acc) check("valid_clear", 32'(rx.rx_valid), 32'd0);
        prev_acc = rx.rx_valid && rx.rx_ready;
        if (prev_acc) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_word: got 0x%0h, required no word", rx.rx_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("rx_data",    32'(rx.rx_data),    32'(e.data));
            check("frame_err",  32'(rx.frame_err),  32'(e.fe));
            check("parity_err", 32'(rx.parity_err), 32'(e.pe));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b, input int clks);
    rxd = b;
    repeat (clks) @(negedge clk);
  endtask

  // Sends one frame; the expectation is queued before the line moves.
  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_bad,
                            input logic par_bit, input bit expect_it);
    exp_t e;
    e.data = d;
    e.fe   = stop_bad;
`ifdef UART_RX_PARITY_EN
    e.pe   = ((($countones(d) + int'(par_bit)) % 2) != PARITY_ODD);
`else
    e.pe   = 1'b0;
`endif
    if (expect_it) sb.push_back(e);
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit, BIT_CLK);
`endif
    for (int i = 0; i < STOP_BITS; i++) drive_bit((i == 0) ? ~stop_bad : 1'b1, BIT_CLK);
    drive_bit(1'b1, 2 * BIT_CLK);
  endtask

  initial begin
    logic [DATA_BITS-1:0] ff_word;
    ff_word = '1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_valid",   32'(rx.rx_valid),   32'd0);
    check("rst_rx_data",    32'(rx.rx_data),    32'd0);
    check("rst_frame_err",  32'(rx.frame_err),  32'd0);
    check("rst_parity_err", 32'(rx.parity_err), 32'd0);
    check("rst_overrun",    32'(rx.overrun),    32'd0);
    check("rst_busy",       32'(busy),          32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frame with the consumer always ready
    ready_mode = 1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);

    // Short low glitch: rejected at the start-bit mid sample
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'd1);
    rxd = 1'b1;
    repeat (25) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // Stop bit sampled low
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);

    // Overrun: second frame dropped while the first is unread
    ready_mode = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    ov_exp++;
    check("ovr_pulse_count", 32'(ov_seen), 32'd1);
    check("ovr_held_valid",  32'(rx.rx_valid), 32'd1);
    check("ovr_held_data",   32'(rx.rx_data),  32'h11);
    ready_mode = 1;
    repeat (4) @(negedge clk);
    check("ovr_valid_drop", 32'(rx.rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07 (three ones): parity bit 0 is wrong, 1 is right
    send_frame(8'h07, 1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1);
`endif

    // Reset in the middle of bit 4 of 0xFF, then a clean 0x5A
    ready_mode = 2;
    drive_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_bit(ff_word[i], BIT_CLK);
    drive_bit(ff_word[4], BIT_CLK / 2);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy",  32'(busy),        32'd0);
    check("midrst_valid", 32'(rx.rx_valid), 32'd0);
    reset = 1'b1;
    drive_bit(1'b1, 3 * BIT_CLK);
    check("postrst_busy", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);

    // Randomised frames with a randomly stalling consumer
    for (int k = 0; k < 12; k++) begin
      send_frame(DATA_BITS'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (16) @(negedge clk);
    check("overrun_total", 32'(ov_seen), 32'(ov_exp));
    check("sb_drained",    32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver: next generation of the team's fixed 8N1 receiver. Adds configurable data width, baud divisor, oversampling ratio and stop-bit count. Also adds a 2-flop input synchroniser, mid-bit sampling, false-start rejection, frame-error and overrun detection, and a valid/ready output holding register. Sits between the pad-side `rxd` line and any byte-stream consumer (command parser, RX FIFO).

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `CLK_DIV`, 27: clk cycles per oversample tick, ≥ 2; 50 MHz / (115200·16) ≈ 27.
- `OVERSAMPLE`, 16: ticks per bit, even, 8..32.
- `STOP_BITS`, 1: stop bits checked, 1 or 2.
- `PARITY_ODD`, 0: parity sense when parity is compiled in; 0 = even, 1 = odd.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `rxd` in 1: asynchronous serial input, idle high.
- `rx_data` out DATA_BITS: received word, LSB first on line.
- `rx_valid` out 1: `rx_data` and error flags valid.
- `rx_ready` in 1: consumer accepts the word when `rx_valid & rx_ready`.
- `frame_err` out 1: stop bit sampled 0; qualified by `rx_valid`.
- `parity_err` out 1: parity mismatch; qualified by `rx_valid`.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser, reset value 1, giving `rxd_s`.
- Tick generator: `div_cnt` counts 0..CLK_DIV-1. `tick` = (`div_cnt` == CLK_DIV-1). The counter is held at 0 in IDLE so the start edge sets phase.
- FSM states and transitions:
  - IDLE → START when `rxd_s` == 0.
  - START: at sample count OVERSAMPLE/2-1 (mid start bit), go → DATA if `rxd_s` is 0. If `rxd_s` is 1 (glitch), go → IDLE with no output.
  - DATA: sample `rxd_s` every OVERSAMPLE ticks at mid-bit and shift it in LSB first. After DATA_BITS samples, go → PARITY (if compiled) or → STOP.
  - PARITY: sample one bit mid-bit; `parity_err` = XOR(data, bit) ≠ PARITY_ODD. Go → STOP.
  - STOP: sample STOP_BITS bits mid-bit. Any 0 sets `frame_err`. After the last stop sample go → IDLE immediately, so a start edge in the second half of the stop bit is caught.
- Output register:
  - On frame completion with `rx_valid` == 0: load `rx_data`, `frame_err` and `parity_err`, and set `rx_valid`.
  - `rx_valid` clears the cycle after `rx_valid & rx_ready`.
  - If `rx_valid` is still 1 when a frame completes, the new frame is discarded, the old data is held and `overrun` pulses for 1 cycle. A handshake in the same cycle as completion counts as free: the new frame loads and there is no overrun.
- Frames with `frame_err` are still delivered; the consumer decides what to do with them.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, synchroniser=1.
- Reset asserted mid-frame aborts immediately. No output is produced after release, and the FSM waits for the next falling edge.
- Latency: `rxd` fall to START is 3 clk (2 sync + 1 FSM). Last stop-bit mid-sample tick to `rx_valid` high is 1 clk.
- Bit period = CLK_DIV·OVERSAMPLE clk; each sample lands at bit centre ±1 tick.
- `busy` is registered and follows the FSM state with 0 extra latency (decoded from the state register).

## Configuration
- `UART_RX_PARITY_EN` defined: a PARITY state follows the data bits, and `parity_err` is computed as above.
- Not defined: no parity bit is expected, the PARITY state and logic are absent, and `parity_err` is tied to 0. The port stays present either way.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Legal ranges for DATA_BITS, OVERSAMPLE and STOP_BITS.
  - `uart_parity` function, shared with the transmitter.
- Sub-module `uart_baud_tick`: divisor counter with synchronous hold-clear input and a `tick` output, reusable by the TX successor.

## Test plan
All tests use CLK_DIV=4, OVERSAMPLE=16, so one bit = 64 clk.
- 8N1 0xA5 with `rx_ready`=1: `rx_data`=0xA5, `rx_valid` high 1 cycle, `frame_err`=0.
- `rxd` low 20 clk then high: no `rx_valid`, `busy` returns to 0 by clk ~35.
- 0x3C sent with stop bit 0: `rx_data`=0x3C, `frame_err`=1.
- 0x11 then 0x22 with `rx_ready`=0: `overrun` pulses once at the second frame end, `rx_data` stays 0x11. With `rx_ready`=1 afterwards, 0x11 is accepted and `rx_valid` drops.
- `UART_RX_PARITY_EN`, PARITY_ODD=0, 0x07 with parity bit 0: `parity_err`=1. Repeat with parity bit 1: `parity_err`=0.
- Reset pulsed during bit 4 of 0xFF, then 0x5A sent: only 0x5A is delivered, with no error flags.
